// File: rtl/program_loader_if.sv
`default_nettype none
// =============================================================================
// Module      : program_loader_if
// Description : Host word stream, IM write port and CPU launch controls of
//               the program loader, bundled for the loader and its host.
// Revision    : 1.0 - initial release
// =============================================================================
interface program_loader_if #(
  parameter int CNT_W = 5
);
  logic             load_req;
  logic             word_valid;
  logic [15:0]      word_data;
  logic             word_last;
  logic             word_ready;
  logic             im_en_write;
  logic [15:0]      im_data_in;
  logic             cpu_reset;
  logic             cpu_start;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] word_count;

  modport master (
    output load_req, word_valid, word_data, word_last,
    input  word_ready, im_en_write, im_data_in, cpu_reset, cpu_start,
           busy, done, overflow, word_count
  );

  modport slave (
    input  load_req, word_valid, word_data, word_last,
    output word_ready, im_en_write, im_data_in, cpu_reset, cpu_start,
           busy, done, overflow, word_count
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// =============================================================================
// Module      : program_loader
// Description : Buffers a host program in a FIFO, replays it to IM as one
//               gap-free burst, then launches the CPU. Optional macro
//               PROGRAM_LOADER_HALT_APPEND_EN appends an HLT (16'h0000) beat.
// Revision    : 1.0 - initial release
// =============================================================================
module program_loader #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam int               c_ptr_w = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_full  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_BURST   = 3'd2,
    S_LAUNCH  = 3'd3,
    S_RUN     = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [15:0]        r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_fifo_count;
  logic [CNT_W-1:0]   r_word_count;
  logic [CNT_W-1:0]   r_burst_idx;
  logic [CNT_W-1:0]   w_burst_last;
  logic               w_halt_beat;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_clr_count;
  logic               w_word_ready;
  logic               w_im_en_write;
  logic [15:0]        w_im_data_in;
  logic               w_cpu_reset;
  logic               w_cpu_start;
  logic               w_busy;
  logic               w_done;
  logic               w_overflow;

`ifdef PROGRAM_LOADER_HALT_APPEND_EN
  // One extra beat past the stored words carries the HLT opcode.
  assign w_burst_last = r_word_count;
  assign w_halt_beat  = (r_burst_idx == r_word_count);
`else
  assign w_burst_last = r_word_count - c_one;
  assign w_halt_beat  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_flush       = 1'b0;
    w_clr_count   = 1'b0;
    w_word_ready  = 1'b0;
    w_im_en_write = 1'b0;
    w_im_data_in  = 16'h0000;
    w_cpu_reset   = 1'b1;
    w_cpu_start   = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_overflow    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_req) begin
          w_next_state = S_COLLECT;
          w_flush      = 1'b1;
          w_clr_count  = 1'b1;
        end
      end
      S_COLLECT: begin
        w_busy       = 1'b1;
        w_word_ready = (r_fifo_count != c_full);
        if (bus.load_req) begin
          w_flush     = 1'b1;
          w_clr_count = 1'b1;
        end else if (bus.word_valid && w_word_ready) begin
          w_push = 1'b1;
          if (bus.word_last) begin
            w_next_state = S_BURST;
          end else if (r_fifo_count == c_last) begin
            w_next_state = S_ERROR;
            w_flush      = 1'b1;
          end
        end
      end
      S_BURST: begin
        w_busy        = 1'b1;
        w_cpu_reset   = 1'b0;
        w_im_en_write = 1'b1;
        w_pop         = !w_halt_beat;
        w_im_data_in  = w_halt_beat ? 16'h0000 : r_mem[r_rd_ptr];
        if (r_burst_idx == w_burst_last) w_next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_busy       = 1'b1;
        w_cpu_start  = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        w_cpu_reset = 1'b0;
        w_cpu_start = 1'b1;
        w_done      = 1'b1;
        if (bus.load_req) begin
          w_next_state = S_COLLECT;
          w_flush      = 1'b1;
          w_clr_count  = 1'b1;
        end
      end
      S_ERROR: begin
        w_overflow = 1'b1;
        if (bus.load_req) begin
          w_next_state = S_COLLECT;
          w_flush      = 1'b1;
          w_clr_count  = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.word_data;
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else if (w_push) begin
      r_wr_ptr     <= r_wr_ptr + 1'b1;
      r_fifo_count <= r_fifo_count + c_one;
    end else if (w_pop) begin
      r_rd_ptr     <= r_rd_ptr + 1'b1;
      r_fifo_count <= r_fifo_count - c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_clr_count) r_word_count <= '0;
    else if (w_push)          r_word_count <= r_word_count + c_one;
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != S_BURST)) r_burst_idx <= '0;
    else                                r_burst_idx <= r_burst_idx + c_one;
  end

  assign bus.word_ready  = w_word_ready;
  assign bus.im_en_write = w_im_en_write;
  assign bus.im_data_in  = w_im_data_in;
  assign bus.cpu_reset   = w_cpu_reset;
  assign bus.cpu_start   = w_cpu_start;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.overflow    = w_overflow;
  assign bus.word_count  = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// =============================================================================
// Module      : tb_program_loader
// Description : Directed bench for program_loader at DEPTH=16 and DEPTH=4;
//               expects the HLT beat when PROGRAM_LOADER_HALT_APPEND_EN is set.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel4;
  logic        load_req, word_valid, word_last;
  logic [15:0] word_data;
  int          vectors = 0;
  int          miscompares = 0;

  program_loader_if #(.CNT_W(5)) b16 ();
  program_loader_if #(.CNT_W(3)) b4 ();

  program_loader #(.DEPTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(b16));
  program_loader #(.DEPTH(4))  u_dut4  (.clk(clk), .reset(reset), .bus(b4));

  always #5 clk = ~clk;

  // Host stimulus is routed to whichever instance is under test.
  assign b16.load_req   = !sel4 && load_req;
  assign b16.word_valid = !sel4 && word_valid;
  assign b16.word_last  = word_last;
  assign b16.word_data  = word_data;
  assign b4.load_req    = sel4 && load_req;
  assign b4.word_valid  = sel4 && word_valid;
  assign b4.word_last   = word_last;
  assign b4.word_data   = word_data;

  logic        v_ready, v_en, v_crst, v_start, v_busy, v_done, v_ovf;
  logic [15:0] v_data;
  logic [4:0]  v_count;
  assign v_ready = sel4 ? b4.word_ready  : b16.word_ready;
  assign v_en    = sel4 ? b4.im_en_write : b16.im_en_write;
  assign v_data  = sel4 ? b4.im_data_in  : b16.im_data_in;
  assign v_crst  = sel4 ? b4.cpu_reset   : b16.cpu_reset;
  assign v_start = sel4 ? b4.cpu_start   : b16.cpu_start;
  assign v_busy  = sel4 ? b4.busy        : b16.busy;
  assign v_done  = sel4 ? b4.done        : b16.done;
  assign v_ovf   = sel4 ? b4.overflow    : b16.overflow;
  assign v_count = sel4 ? {2'b00, b4.word_count} : b16.word_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    word_valid = 1'b1;
    word_data  = d;
    word_last  = last;
    tick();
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic burst_check(input string tag, input logic [15:0] w [4], input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_en"},   {31'd0, v_en},   32'd1);
      chk({tag, "_data"}, {16'd0, v_data}, {16'd0, w[i]});
      chk({tag, "_crst"}, {31'd0, v_crst}, 32'd0);
      tick();
    end
`ifdef PROGRAM_LOADER_HALT_APPEND_EN
    chk({tag, "_hlt_en"},   {31'd0, v_en},   32'd1);
    chk({tag, "_hlt_data"}, {16'd0, v_data}, 32'h0000);
    tick();
`endif
    chk({tag, "_launch_en"},    {31'd0, v_en},    32'd0);
    chk({tag, "_launch_data"},  {16'd0, v_data},  32'h0000);
    chk({tag, "_launch_crst"},  {31'd0, v_crst},  32'd1);
    chk({tag, "_launch_start"}, {31'd0, v_start}, 32'd1);
    tick();
    chk({tag, "_run_done"},  {31'd0, v_done},  32'd1);
    chk({tag, "_run_start"}, {31'd0, v_start}, 32'd1);
    chk({tag, "_run_crst"},  {31'd0, v_crst},  32'd0);
    chk({tag, "_run_busy"},  {31'd0, v_busy},  32'd0);
  endtask

  initial begin
    logic [15:0] prog [4];
    reset = 1'b1; sel4 = 1'b0; load_req = 1'b0;
    word_valid = 1'b0; word_last = 1'b0; word_data = 16'h0000;
    tick(); tick();

    chk("rst_crst",  {31'd0, v_crst},  32'd1);
    chk("rst_ready", {31'd0, v_ready}, 32'd0);
    chk("rst_en",    {31'd0, v_en},    32'd0);
    chk("rst_data",  {16'd0, v_data},  32'd0);
    chk("rst_start", {31'd0, v_start}, 32'd0);
    chk("rst_busy",  {31'd0, v_busy},  32'd0);
    chk("rst_done",  {31'd0, v_done},  32'd0);
    chk("rst_ovf",   {31'd0, v_ovf},   32'd0);
    chk("rst_count", {27'd0, v_count}, 32'd0);
    reset = 1'b0;

    // Words offered in IDLE must be ignored.
    send(16'hDEAD, 1'b1);
    chk("idle_count", {27'd0, v_count}, 32'd0);
    chk("idle_busy",  {31'd0, v_busy},  32'd0);

    // Happy path.
    pulse_load();
    chk("hp_busy",  {31'd0, v_busy},  32'd1);
    chk("hp_ready", {31'd0, v_ready}, 32'd1);
    chk("hp_crst",  {31'd0, v_crst},  32'd1);
    send(16'h400A, 1'b0);
    send(16'h4408, 1'b0);
    send(16'h4300, 1'b1);
    chk("hp_count", {27'd0, v_count}, 32'd3);
    prog[0] = 16'h400A; prog[1] = 16'h4408; prog[2] = 16'h4300; prog[3] = 16'h0000;
    burst_check("hp", prog, 3);

    // Reload from RUN.
    pulse_load();
    chk("rl_start", {31'd0, v_start}, 32'd0);
    chk("rl_crst",  {31'd0, v_crst},  32'd1);
    chk("rl_done",  {31'd0, v_done},  32'd0);
    chk("rl_count", {27'd0, v_count}, 32'd0);
    send(16'h1111, 1'b0);
    chk("rl_mid_start", {31'd0, v_start}, 32'd0);
    send(16'h2222, 1'b1);
    chk("rl_count2", {27'd0, v_count}, 32'd2);
    prog[0] = 16'h1111; prog[1] = 16'h2222;
    burst_check("rl", prog, 2);

    // Host gaps, preceded by a word that collides with load_req and is dropped.
    pulse_load();
    load_req = 1'b1;
    send(16'hBEEF, 1'b1);
    load_req = 1'b0;
    chk("col_count", {27'd0, v_count}, 32'd0);
    chk("col_busy",  {31'd0, v_busy},  32'd1);
    send(16'h400A, 1'b0);
    tick(); tick();
    chk("gap_ready", {31'd0, v_ready}, 32'd1);
    chk("gap_en",    {31'd0, v_en},    32'd0);
    send(16'h4408, 1'b0);
    tick(); tick();
    send(16'h4300, 1'b1);
    chk("gap_count", {27'd0, v_count}, 32'd3);
    prog[0] = 16'h400A; prog[1] = 16'h4408; prog[2] = 16'h4300;
    burst_check("gap", prog, 3);

    // Reset during the second burst cycle.
    pulse_load();
    send(16'h0A01, 1'b0);
    send(16'h0A02, 1'b0);
    send(16'h0A03, 1'b1);
    chk("mb_en0",   {31'd0, v_en},   32'd1);
    chk("mb_data0", {16'd0, v_data}, 32'h0A01);
    tick();
    chk("mb_data1", {16'd0, v_data}, 32'h0A02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mb_en",    {31'd0, v_en},    32'd0);
    chk("mb_crst",  {31'd0, v_crst},  32'd1);
    chk("mb_count", {27'd0, v_count}, 32'd0);
    chk("mb_busy",  {31'd0, v_busy},  32'd0);
    chk("mb_data",  {16'd0, v_data},  32'd0);
    tick();
    chk("mb_noresume", {31'd0, v_en}, 32'd0);

    // Overflow on the DEPTH=4 instance.
    sel4 = 1'b1;
    pulse_load();
    send(16'hA001, 1'b0);
    send(16'hA002, 1'b0);
    send(16'hA003, 1'b0);
    chk("ov_ready3", {31'd0, v_ready}, 32'd1);
    send(16'hA004, 1'b0);
    chk("ov_ready4", {31'd0, v_ready}, 32'd0);
    chk("ov_flag",   {31'd0, v_ovf},   32'd1);
    chk("ov_busy",   {31'd0, v_busy},  32'd0);
    chk("ov_crst",   {31'd0, v_crst},  32'd1);
    chk("ov_en",     {31'd0, v_en},    32'd0);
    tick();
    chk("ov_sticky", {31'd0, v_ovf},   32'd1);
    chk("ov_en2",    {31'd0, v_en},    32'd0);
    pulse_load();
    chk("ov_clr",   {31'd0, v_ovf},   32'd0);
    chk("ov_busy2", {31'd0, v_busy},  32'd1);
    chk("ov_count", {27'd0, v_count}, 32'd0);

    // Exact fill: word_last together with the FIFO reaching full.
    send(16'hB001, 1'b0);
    send(16'hB002, 1'b0);
    send(16'hB003, 1'b0);
    send(16'hB004, 1'b1);
    chk("ef_ovf",   {31'd0, v_ovf},   32'd0);
    chk("ef_count", {27'd0, v_count}, 32'd4);
    prog[0] = 16'hB001; prog[1] = 16'hB002; prog[2] = 16'hB003; prog[3] = 16'hB004;
    burst_check("ef", prog, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
